// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   MEM-stage load/store unit. Accepts one load or store from the core, issues
//   a single word-aligned request on the data-memory port, waits for the grant
//   and (for loads) the read response, then pulses o_done for one cycle.
//   Load data is aligned, truncated to the access size and sign/zero extended.
//   Store data is replicated across the byte lanes selected by o_dmem_be.
//
// Optional feature:
//   MISALIGN_TRAP_EN -- when defined, a misaligned half/word access skips the
//   memory request and completes at once with o_misaligned=1. When undefined,
//   o_misaligned is tied 0 and the low address bits that would misalign the
//   access are ignored.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_valid             instruction present in MEM stage
//   i_mem_read/write    operation; both high is treated as a load
//   i_d_size            00 byte, 01 half, 10/11 word
//   i_d_unsigned        zero-extend (1) or sign-extend (0) load data
//   i_addr, i_wdata     byte address and store data
//   o_stall             hold the pipeline while the access is in flight
//   o_done              one-cycle completion pulse
//   o_rdata             extended load data, held until the next load completes
//   o_misaligned        misaligned-access flag, valid with o_done
//   o_dmem_*            request side of the data-memory port
//   i_dmem_gnt          request accepted by memory
//   i_dmem_rvalid       read data valid on i_dmem_rdata
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_d_size,
  input  logic        i_d_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_e      state_q, state_d;
  logic [31:0] daddr_q, daddr_d;     // word-aligned request address
  logic [1:0]  off_q, off_d;         // effective byte offset inside the word
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        store_q, store_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;     // lane-replicated store data
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        capture;
  logic        misaligned_in;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  // Shift the addressed bytes down to bit 0, keep the access width, extend.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_extend = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  // An op is taken only in IDLE; reset blocks acceptance so o_stall stays low.
  assign accept = (state_q == S_IDLE) && i_valid && (i_mem_read || i_mem_write) && !i_rst;

  // Load data is taken either together with the grant or later in WAIT.
  assign capture = ((state_q == S_REQ) && i_dmem_gnt && i_dmem_rvalid && !store_q) ||
                   ((state_q == S_WAIT) && i_dmem_rvalid);

  // Effective offset, byte enables and replicated store data for the new op.
  // Offset bits that would misalign a half/word are dropped here, so the
  // non-trapping build naturally ignores them.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    off_in   = 2'b00;
    be_in    = 4'b1111;
    wdata_in = i_wdata;
    case (i_d_size)
      SZ_BYTE: begin
        off_in   = i_addr[1:0];
        be_in    = 4'b0001 << i_addr[1:0];
        wdata_in = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        off_in   = {i_addr[1], 1'b0};
        be_in    = 4'b0011 << {i_addr[1], 1'b0};
        wdata_in = {2{i_wdata[15:0]}};
      end
      default: begin
        off_in   = 2'b00;
        be_in    = 4'b1111;
        wdata_in = i_wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  always_comb begin
    misaligned_in = 1'b0;
    case (i_d_size)
      SZ_BYTE: misaligned_in = 1'b0;
      SZ_HALF: misaligned_in = i_addr[0];
      default: misaligned_in = (i_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    mis_d = mis_q;
    if (accept) mis_d = misaligned_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign o_misaligned = (state_q == S_DONE) && mis_q;
`else
  assign misaligned_in = 1'b0;
  assign o_misaligned  = 1'b0;
`endif

  // Next-state logic. gnt/rvalid are only looked at in REQ and WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = misaligned_in ? S_DONE : S_REQ;
      S_REQ: begin
        if (i_dmem_gnt) begin
          if (store_q || i_dmem_rvalid) state_d = S_DONE;
          else                          state_d = S_WAIT;
        end
      end
      S_WAIT: if (i_dmem_rvalid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operation latch and load-data register.
  always_comb begin
    daddr_d = daddr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      daddr_d = {i_addr[31:2], 2'b00};
      off_d   = off_in;
      size_d  = i_d_size;
      uns_d   = i_d_unsigned;
      store_d = i_mem_write && !i_mem_read;  // read wins when both are set
      be_d    = be_in;
      wdata_d = wdata_in;
    end
    if (capture) rdata_d = load_extend(i_dmem_rdata, off_q, size_q, uns_q);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  // NOTE: all data registers are reset, not just the FSM, because the memory
  // port and o_rdata must read as zero straight out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      daddr_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      daddr_q <= daddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields come straight from registers, so they cannot move while
  // the request waits for its grant.
  assign o_stall      = accept || (state_q == S_REQ) || (state_q == S_WAIT);
  assign o_done       = (state_q == S_DONE);
  assign o_rdata      = rdata_q;
  assign o_dmem_req   = (state_q == S_REQ);
  assign o_dmem_we    = (state_q == S_REQ) && store_q;
  assign o_dmem_addr  = daddr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: i_clk in 1 (clock, rising edge); i_rst in 1 (reset, synchronous, active-high).
REQ-002 SHALL have core ports:
- i_valid in 1 (instruction in MEM stage)
- i_mem_read in 1
- i_mem_write in 1
- i_d_size in 2 (00 byte, 01 half, 10 word)
- i_d_unsigned in 1
- i_addr in 32
- i_wdata in 32
- o_stall out 1
- o_done out 1
- o_rdata out 32 (extended load data)
- o_misaligned out 1
REQ-003 SHALL have memory ports:
- o_dmem_req out 1
- o_dmem_we out 1
- o_dmem_addr out 32 (word-aligned)
- o_dmem_be out 4
- o_dmem_wdata out 32
- i_dmem_gnt in 1
- i_dmem_rvalid in 1
- i_dmem_rdata in 32

Function
REQ-004 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-005 In IDLE, i_valid and (i_mem_read or i_mem_write) SHALL latch addr, size, unsigned, wdata and op, then go to REQ next cycle; otherwise remain in IDLE.
REQ-006 When i_mem_read and i_mem_write are both high, the op SHALL be a load.
REQ-007 o_stall SHALL be 1 in REQ and WAIT, and in the IDLE cycle accepting an op; it SHALL be 0 in DONE.
REQ-008 In REQ, o_dmem_req SHALL be 1 and all o_dmem_* SHALL be held stable until i_dmem_gnt.
REQ-009 In REQ with gnt, a store SHALL go to DONE.
REQ-010 In REQ with gnt, a load with rvalid in the same cycle SHALL capture data and go to DONE; a load without rvalid SHALL go to WAIT.
REQ-011 WAIT SHALL hold until i_dmem_rvalid, capture data, then go to DONE.
REQ-012 DONE SHALL last one cycle with o_done=1, then return to IDLE; new ops SHALL NOT be accepted in DONE.
REQ-013 o_dmem_addr SHALL be {addr[31:2],2'b00}; o_dmem_we SHALL be 1 for stores.
REQ-014 o_dmem_be SHALL be: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; size 11 treated as word.
REQ-015 o_dmem_wdata SHALL be: byte replicated 4x; half replicated 2x; word unchanged.
REQ-016 Load data SHALL be i_dmem_rdata >> (8*addr[1:0]), truncated to size, then zero-extended if unsigned, else sign-extended.
REQ-017 o_rdata SHALL be registered, valid in DONE, and held until the next load completes.
REQ-018 i_dmem_rvalid and i_dmem_gnt SHALL be ignored in IDLE and DONE.

Reset
REQ-019 Reset SHALL force IDLE and drive o_stall, o_done, o_misaligned, o_dmem_req, o_dmem_we = 0; o_dmem_addr, o_dmem_be, o_dmem_wdata, o_rdata = 0.
REQ-020 Reset mid-operation SHALL abandon the access; a late rvalid SHALL be discarded.

Configuration
REQ-021 With MISALIGN_TRAP_EN defined, a misaligned op SHALL skip the memory request and go IDLE -> DONE with o_misaligned=1, o_rdata unchanged, and o_done=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-022 Without MISALIGN_TRAP_EN, o_misaligned SHALL be tied 0 and misaligned low address bits SHALL be ignored: half uses addr[1] only, word uses neither.

Verification
REQ-023 SHALL cover LB at addr 0x103 with rdata 0x80AA5511, gnt and rvalid same cycle: be=1000, DONE on the 3rd cycle, o_rdata=0xFFFFFF80.
REQ-024 SHALL cover LHU at 0x102 with rdata 0x8001xxxx and rvalid 3 cycles after gnt: stall is held throughout, o_rdata=0x00008001.
REQ-025 SHALL cover SB at 0x201 with wdata 0x123456AB and gnt delayed 2 cycles: req/addr/be/wdata are stable; addr=0x200, be=0010, wdata=0xABABABAB.
REQ-026 SHALL cover LW at 0x006 with MISALIGN_TRAP_EN: no o_dmem_req, o_misaligned=1 and o_done=1 in DONE. Without the macro, addr=0x004 and be=1111.
REQ-027 SHALL cover reset asserted in WAIT followed by rvalid: the FSM is in IDLE, o_done is never pulsed, and o_rdata=0.
REQ-028 SHALL cover i_mem_read=i_mem_write=1: o_dmem_we=0 and the load completes normally.
